// File: rtl/program_counter_stack.sv
`default_nettype none
// ============================================================================
// Module   : program_counter_stack
// Purpose  : SAP-2 program counter with a hardware return-address stack.
//            Increment, jump, CALL (push return address, then jump) and
//            RET (pop into PC), with tri-state W-bus drive in full, high-half
//            and low-half modes. State changes on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module program_counter_stack #(
  parameter int               WIDTH        = 16,
  parameter int               STACK_DEPTH  = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                               iClk,
  input  logic                               iReset,
  input  logic                               iIncrement,
  input  logic                               iLoad,
  input  logic                               iCall,
  input  logic                               iReturn,
  input  logic                               iClearErr,
  input  logic [WIDTH-1:0]                   iInput,
  input  logic                               eFull,
  input  logic                               eHigh,
  input  logic                               eLow,
  output logic [WIDTH-1:0]                   oProgramCounter,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   oStackDepth,
  output logic                               oOverflow,
  output logic                               oUnderflow,
  output tri   [WIDTH-1:0]                   tWbus
);

  // Width of the depth counter (0..STACK_DEPTH) and of a stack slot index.
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int PTR_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int HALF    = WIDTH / 2;

  localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);
  localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);
  localparam logic [WIDTH-1:0]   PC_ONE     = WIDTH'(1);

  // --------------------------------------------------------------------------
  // Architectural state
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]   pc;
  logic [DEPTH_W-1:0] depth;
  logic               overflow;
  logic               underflow;
  logic [WIDTH-1:0]   stack [STACK_DEPTH];

  // --------------------------------------------------------------------------
  // Command decode: a single command wins per edge (CALL > RET > LOAD > INC)
  // --------------------------------------------------------------------------
  logic do_call;
  logic do_ret;
  logic do_load;
  logic do_inc;
  logic stack_full;
  logic stack_empty;

  // Resolve the one-hot winning command from the raw control word.
  always_comb begin
    do_call = iCall;
    do_ret  = !iCall && iReturn;
    do_load = !iCall && !iReturn && iLoad;
    do_inc  = !iCall && !iReturn && !iLoad && iIncrement;
  end

  assign stack_full  = (depth == DEPTH_FULL);
  assign stack_empty = (depth == '0);

  // --------------------------------------------------------------------------
  // Next-state computation
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]   pc_plus_one;
  logic [PTR_W-1:0]   push_idx;
  logic [PTR_W-1:0]   pop_idx;
  logic [WIDTH-1:0]   pc_next;
  logic [DEPTH_W-1:0] depth_next;
  logic               push_en;
  logic               overflow_evt;
  logic               underflow_evt;
  logic               overflow_next;
  logic               underflow_next;

  assign pc_plus_one = pc + PC_ONE;
  // Slot indices are only used when the depth guarantees they are in range
  // (push only when not full, pop only when not empty).
  assign push_idx    = PTR_W'(depth);
  assign pop_idx     = PTR_W'(depth - DEPTH_ONE);

  // Compute PC, depth and push request for the winning command.
  always_comb begin
    pc_next       = pc;
    depth_next    = depth;
    push_en       = 1'b0;
    overflow_evt  = 1'b0;
    underflow_evt = 1'b0;

    if (do_call) begin
      if (stack_full) begin
        // A call that cannot save its return address is dropped entirely.
        overflow_evt = 1'b1;
      end else begin
        push_en    = 1'b1;
        depth_next = depth + DEPTH_ONE;
        pc_next    = iInput;
      end
    end else if (do_ret) begin
      if (stack_empty) begin
        underflow_evt = 1'b1;
      end else begin
        depth_next = depth - DEPTH_ONE;
        pc_next    = stack[pop_idx];
      end
    end else if (do_load) begin
      pc_next = iInput;
    end else if (do_inc) begin
      pc_next = pc_plus_one;
    end
  end

  // Sticky error flags: a new error on the same edge beats a clear request.
  always_comb begin
    overflow_next  = overflow;
    underflow_next = underflow;
    if (iClearErr) begin
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end
    if (overflow_evt) begin
      overflow_next = 1'b1;
    end
    if (underflow_evt) begin
      underflow_next = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  // PC, depth and error flags update on the falling edge; reset is async.
  always_ff @(negedge iClk or negedge iReset) begin
    if (!iReset) begin
      pc        <= RESET_VECTOR;
      depth     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pc        <= pc_next;
      depth     <= depth_next;
      overflow  <= overflow_next;
      underflow <= underflow_next;
    end
  end

  // Stack storage needs no reset: slots at or above depth are never read.
  always_ff @(negedge iClk) begin
    if (push_en) begin
      stack[push_idx] <= pc_plus_one;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign oProgramCounter = pc;
  assign oStackDepth     = depth;
  assign oOverflow       = overflow;
  assign oUnderflow      = underflow;

  // --------------------------------------------------------------------------
  // W-bus drive (combinational, eFull > eHigh > eLow)
  // --------------------------------------------------------------------------
  logic            drive_upper;
  logic            drive_lower;
  logic [HALF-1:0] lower_val;

  // Choose which PC half lands on the low bus lane.
  always_comb begin
    drive_upper = eFull;
    drive_lower = eFull || eHigh || eLow;
    if (eFull) begin
      lower_val = pc[HALF-1:0];
    end else if (eHigh) begin
      lower_val = pc[WIDTH-1:HALF];
    end else begin
      lower_val = pc[HALF-1:0];
    end
  end

  assign tWbus[WIDTH-1:HALF] = drive_upper ? pc[WIDTH-1:HALF] : {(WIDTH-HALF){1'bz}};
  assign tWbus[HALF-1:0]     = drive_lower ? lower_val        : {HALF{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_program_counter_stack.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_counter_stack
// Purpose  : Self-checking bench for program_counter_stack. Directed test
//            plan steps followed by randomized commands, all checked against
//            a queue-based behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_program_counter_stack;

  localparam int SD = 4;

  logic        clk;
  logic        rst_n;
  logic        inc;
  logic        load;
  logic        call;
  logic        ret;
  logic        clr;
  logic [15:0] din;
  logic        e_full;
  logic        e_high;
  logic        e_low;
  logic [15:0] pc_o;
  logic [2:0]  depth_o;
  logic        ovf_o;
  logic        unf_o;
  tri   [15:0] wbus;

  // Second bus agent used to probe which lanes the DUT has released.
  logic        tb_en_hi;
  logic        tb_en_lo;
  logic [15:0] tb_val;
  assign wbus[15:8] = tb_en_hi ? tb_val[15:8] : 8'bz;
  assign wbus[7:0]  = tb_en_lo ? tb_val[7:0]  : 8'bz;

  program_counter_stack #(
    .WIDTH       (16),
    .STACK_DEPTH (SD),
    .RESET_VECTOR(16'h0000)
  ) dut (
    .iClk           (clk),
    .iReset         (rst_n),
    .iIncrement     (inc),
    .iLoad          (load),
    .iCall          (call),
    .iReturn        (ret),
    .iClearErr      (clr),
    .iInput         (din),
    .eFull          (e_full),
    .eHigh          (e_high),
    .eLow           (e_low),
    .oProgramCounter(pc_o),
    .oStackDepth    (depth_o),
    .oOverflow      (ovf_o),
    .oUnderflow     (unf_o),
    .tWbus          (wbus)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: PC value, LIFO of return addresses, sticky flags.
  logic [15:0] m_pc;
  logic [15:0] m_stack[$];
  logic        m_ovf;
  logic        m_unf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000;
    m_stack.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step(input logic c, input logic r, input logic l,
                            input logic i, input logic cl, input logic [15:0] d);
    if (cl) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (c) begin
      if (m_stack.size() == SD) m_ovf = 1'b1;
      else begin
        m_stack.push_back(m_pc + 16'd1);
        m_pc = d;
      end
    end else if (r) begin
      if (m_stack.size() == 0) m_unf = 1'b1;
      else m_pc = m_stack.pop_back();
    end else if (l) begin
      m_pc = d;
    end else if (i) begin
      m_pc = m_pc + 16'd1;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_pc"},    pc_o,    m_pc);
    check({tag, "_depth"}, depth_o, m_stack.size());
    check({tag, "_ovf"},   ovf_o,   m_ovf);
    check({tag, "_unf"},   unf_o,   m_unf);
  endtask

  // Apply one command across a falling edge, update the model, check state.
  task automatic cmd(input string tag, input logic c, input logic r, input logic l,
                     input logic i, input logic cl, input logic [15:0] d);
    call = c; ret = r; load = l; inc = i; clr = cl; din = d;
    @(negedge clk);
    #1;
    call = 0; ret = 0; load = 0; inc = 0; clr = 0;
    model_step(c, r, l, i, cl, d);
    check_state(tag);
  endtask

  task automatic set_bus(input logic f, input logic h, input logic l);
    e_full = f; e_high = h; e_low = l;
    #1;
  endtask

  initial begin
    rst_n = 0; inc = 0; load = 0; call = 0; ret = 0; clr = 0; din = '0;
    e_full = 0; e_high = 0; e_low = 0;
    tb_en_hi = 0; tb_en_lo = 0; tb_val = '0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_state("reset");
    rst_n = 1;

    // Reset and increment
    for (int k = 0; k < 3; k++) cmd("inc", 0, 0, 0, 1, 0, 16'h0);
    check("inc3_pc", pc_o, 16'h0003);
    #2 rst_n = 0;
    #1;
    model_reset();
    check("async_rst_pc", pc_o, 16'h0000);
    rst_n = 1;
    @(negedge clk); #1;
    check_state("post_rst");

    // Wrap-around
    cmd("ld_ffff", 0, 0, 1, 0, 0, 16'hFFFF);
    cmd("wrap", 0, 0, 0, 1, 0, 16'h0);
    check("wrap_pc", pc_o, 16'h0000);

    // Nested call/return
    cmd("ld_10", 0, 0, 1, 0, 0, 16'h0010);
    cmd("call1", 1, 0, 0, 0, 0, 16'h0100);
    cmd("call2", 1, 0, 0, 0, 0, 16'h0200);
    check("call2_pc", pc_o, 16'h0200);
    cmd("ret1", 0, 1, 0, 0, 0, 16'h0);
    check("ret1_pc", pc_o, 16'h0101);
    cmd("ret2", 0, 1, 0, 0, 0, 16'h0);
    check("ret2_pc", pc_o, 16'h0011);

    // Overflow then underflow
    for (int k = 0; k < 5; k++) cmd("ovf_call", 1, 0, 0, 0, 0, 16'h1000 + 16'(k));
    check("ovf_pc", pc_o, 16'h1003);
    check("ovf_flag", ovf_o, 1'b1);
    for (int k = 0; k < 4; k++) cmd("drain", 0, 1, 0, 0, 0, 16'h0);
    cmd("unf_ret", 0, 1, 0, 0, 0, 16'h0);
    check("unf_flag", unf_o, 1'b1);
    cmd("clr", 0, 0, 0, 0, 1, 16'h0);
    check("clr_flags", {ovf_o, unf_o}, 2'b00);
    // Clear and a fresh underflow on the same edge: the flag must stay set.
    cmd("clr_vs_err", 0, 1, 0, 0, 1, 16'h0);
    check("clr_vs_err_unf", unf_o, 1'b1);
    cmd("clr2", 0, 0, 0, 0, 1, 16'h0);

    // Priority
    cmd("prio_all", 1, 1, 1, 1, 0, 16'h0777);
    check("prio_all_pc", pc_o, 16'h0777);
    cmd("prio_li", 0, 0, 1, 1, 0, 16'h0042);
    check("prio_li_pc", pc_o, 16'h0042);

    // Bus modes
    cmd("ld_a5c3", 0, 0, 1, 0, 0, 16'hA5C3);
    set_bus(1, 0, 0);
    check("bus_full", wbus, 16'hA5C3);
    set_bus(0, 1, 0);
    check("bus_high_lo", wbus[7:0], 8'hA5);
    tb_en_hi = 1; tb_val = 16'h0000; #1;
    check("bus_high_up0", wbus[15:8], 8'h00);
    tb_val = 16'hFFFF; #1;
    check("bus_high_upF", wbus[15:8], 8'hFF);
    tb_en_hi = 0;
    set_bus(0, 0, 1);
    check("bus_low_lo", wbus[7:0], 8'hC3);
    tb_en_hi = 1; tb_val = 16'h0000; #1;
    check("bus_low_up0", wbus[15:8], 8'h00);
    tb_val = 16'hFFFF; #1;
    check("bus_low_upF", wbus[15:8], 8'hFF);
    tb_en_hi = 0;
    set_bus(0, 1, 1);
    check("bus_hl", wbus[7:0], 8'hA5);
    set_bus(0, 0, 0);
    tb_en_hi = 1; tb_en_lo = 1; tb_val = 16'h0000; #1;
    check("bus_none0", wbus, 16'h0000);
    tb_val = 16'hFFFF; #1;
    check("bus_none1", wbus, 16'hFFFF);
    tb_en_hi = 0; tb_en_lo = 0;

    // Randomized commands with the full bus enabled
    set_bus(1, 0, 0);
    for (int n = 0; n < 400; n++) begin
      int unsigned sel;
      sel = $urandom_range(0, 99);
      if (sel < 2) begin
        #2 rst_n = 0;
        #1;
        model_reset();
        check_state("rnd_rst");
        rst_n = 1;
        @(negedge clk); #1;
      end else begin
        cmd("rnd",
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 1) == 0),
            ($urandom_range(0, 9) == 0),
            16'($urandom()));
        check("rnd_bus", wbus, m_pc);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
